// File: rtl/pit_irq_ctrl_if.sv
// Signal bundle between the interval timer's consumer side and pit_irq_ctrl.
// The master drives timer/consumer controls; the slave returns interrupt state and statistics.
interface pit_irq_ctrl_if #(
  parameter int MISSED_W = 8,
  parameter int EVENT_W  = 16
) ();
  logic                counter_set;
  logic                interrupting;
  logic                irq_enable;
  logic                ack;
  logic                clear_stats;
  logic                irq;
  logic                pending;
  logic                irq_pulse;
  logic [MISSED_W-1:0] missed_count;
  logic [EVENT_W-1:0]  event_count;

  modport master (
    output counter_set, interrupting, irq_enable, ack, clear_stats,
    input  irq, pending, irq_pulse, missed_count, event_count
  );

  modport slave (
    input  counter_set, interrupting, irq_enable, ack, clear_stats,
    output irq, pending, irq_pulse, missed_count, event_count
  );
endinterface

// File: rtl/pit_irq_ctrl.sv
// Interrupt controller behind the interval timer: sticky maskable irq with ack,
// retriggerable stretched pulse, and saturating/wrapping event statistics.
module pit_irq_ctrl #(
  parameter int PULSE_CYCLES = 4,
  parameter int MISSED_W     = 8,
  parameter int EVENT_W      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  pit_irq_ctrl_if.slave bus
);

  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t              state;
  logic                int_q;
  logic [7:0]          pulse_cnt;
  logic [MISSED_W-1:0] missed_q;
  logic [EVENT_W-1:0]  event_q;
  logic                ev;

  function automatic logic [MISSED_W-1:0] sat_inc(input logic [MISSED_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A held level yields a single event; int_q resetting low makes a level present at release count once.
  assign ev = bus.interrupting & ~int_q & bus.counter_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      int_q     <= 1'b0;
      pulse_cnt <= 8'd0;
      missed_q  <= '0;
      event_q   <= '0;
    end else begin
      int_q <= bus.interrupting;

      case (state)
        IDLE: if (ev) state <= PEND;
        PEND: if (bus.ack && !ev) state <= IDLE;
        default: state <= IDLE;
      endcase

      // An ack coinciding with a new event consumes the old one, so nothing is missed.
      if (bus.clear_stats)
        missed_q <= '0;
      else if (state == PEND && ev && !bus.ack)
        missed_q <= sat_inc(missed_q);

      if (bus.clear_stats)
        event_q <= '0;
      else if (ev)
        event_q <= event_q + 1'b1;

      if (ev)
        pulse_cnt <= PULSE_LOAD;
      else if (pulse_cnt != 8'd0)
        pulse_cnt <= pulse_cnt - 8'd1;
    end
  end

  assign bus.pending      = (state == PEND);
  assign bus.irq          = (state == PEND) & bus.irq_enable;
  assign bus.irq_pulse    = (pulse_cnt != 8'd0);
  assign bus.missed_count = missed_q;
  assign bus.event_count  = event_q;

endmodule

// File: tb/tb_pit_irq_ctrl.sv
// Directed and randomized bench for pit_irq_ctrl against an event-level reference model.
module tb_pit_irq_ctrl;
  localparam int PULSE_CYCLES = 4;
  localparam int MISSED_W     = 8;
  localparam int EVENT_W      = 16;
  localparam int MISSED_MAX   = (1 << MISSED_W) - 1;
  localparam int EVENT_MOD    = (1 << EVENT_W);

  logic clk = 1'b0;
  logic rst_n;

  pit_irq_ctrl_if #(.MISSED_W(MISSED_W), .EVENT_W(EVENT_W)) bus ();

  pit_irq_ctrl #(
    .PULSE_CYCLES(PULSE_CYCLES),
    .MISSED_W    (MISSED_W),
    .EVENT_W     (EVENT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: what the consumer should observe, tracked as plain integers.
  bit m_pending;
  int m_missed;
  int m_events;
  int m_pulse_left;
  bit m_prev_level;

  task automatic model_reset();
    m_pending    = 0;
    m_missed     = 0;
    m_events     = 0;
    m_pulse_left = 0;
    m_prev_level = 0;
  endtask

  task automatic model_edge();
    bit new_event;
    if (!rst_n) begin
      model_reset();
      return;
    end
    new_event = bus.interrupting && !m_prev_level && bus.counter_set;
    if (bus.clear_stats) begin
      m_missed = 0;
      m_events = 0;
    end else begin
      if (new_event && m_pending && !bus.ack && m_missed < MISSED_MAX) m_missed++;
      if (new_event) m_events = (m_events + 1) % EVENT_MOD;
    end
    if (new_event)      m_pending = 1;
    else if (bus.ack)   m_pending = 0;
    if (new_event)      m_pulse_left = PULSE_CYCLES;
    else if (m_pulse_left > 0) m_pulse_left--;
    m_prev_level = bus.interrupting;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pending"},   32'(bus.pending),      32'(m_pending));
    chk({tag, ".irq"},       32'(bus.irq),          32'(m_pending && bus.irq_enable));
    chk({tag, ".irq_pulse"}, 32'(bus.irq_pulse),    32'(m_pulse_left > 0));
    chk({tag, ".missed"},    32'(bus.missed_count), 32'(m_missed));
    chk({tag, ".events"},    32'(bus.event_count),  32'(m_events));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_int(input string tag);
    bus.interrupting = 1'b1;
    step(tag);
    bus.interrupting = 1'b0;
    step(tag);
  endtask

  initial begin
    int hi_cnt;
    rst_n            = 1'b0;
    bus.counter_set  = 1'b0;
    bus.interrupting = 1'b0;
    bus.irq_enable   = 1'b0;
    bus.ack          = 1'b0;
    bus.clear_stats  = 1'b0;
    model_reset();
    repeat (3) step("reset");
    chk("reset_pending", 32'(bus.pending), 32'd0);
    rst_n = 1'b1;

    // Basic: one-cycle interrupt at cycle 10, ack at cycle 20.
    bus.counter_set = 1'b1;
    bus.irq_enable  = 1'b1;
    repeat (10) step("basic_idle");
    bus.interrupting = 1'b1;
    step("basic_edge");
    bus.interrupting = 1'b0;
    chk("basic_irq", 32'(bus.irq), 32'd1);
    hi_cnt = 1;
    for (int i = 0; i < 8; i++) begin
      step("basic_run");
      if (bus.irq_pulse) hi_cnt++;
    end
    chk("basic_pulse_width", 32'(hi_cnt), 32'(PULSE_CYCLES));
    chk("basic_events", 32'(bus.event_count), 32'd1);
    bus.ack = 1'b1;
    step("basic_ack");
    bus.ack = 1'b0;
    chk("basic_ack_pending", 32'(bus.pending), 32'd0);
    step("ack_idle");
    bus.ack = 1'b1;
    step("ack_in_idle");
    bus.ack = 1'b0;

    // Missed saturation over 300 edges with no ack.
    bus.clear_stats = 1'b1;
    step("clear0");
    bus.clear_stats = 1'b0;
    for (int i = 0; i < 300; i++) pulse_int("sat");
    chk("sat_missed", 32'(bus.missed_count), 32'd255);
    chk("sat_events", 32'(bus.event_count), 32'd300);
    chk("sat_pending", 32'(bus.pending), 32'd1);

    // Simultaneous ack and event while pending.
    bus.clear_stats = 1'b1;
    step("clear1");
    bus.clear_stats = 1'b0;
    pulse_int("miss_one");
    chk("miss_one", 32'(bus.missed_count), 32'd1);
    bus.ack = 1'b1;
    bus.interrupting = 1'b1;
    step("ack_ev");
    bus.ack = 1'b0;
    bus.interrupting = 1'b0;
    chk("ack_ev_pending", 32'(bus.pending), 32'd1);
    chk("ack_ev_missed", 32'(bus.missed_count), 32'd1);
    chk("ack_ev_events", 32'(bus.event_count), 32'd2);
    step("ack_ev_after");

    // Mask then unmask.
    bus.ack = 1'b1;
    step("mask_ack");
    bus.ack = 1'b0;
    bus.irq_enable = 1'b0;
    pulse_int("mask_ev");
    chk("mask_pending", 32'(bus.pending), 32'd1);
    chk("mask_irq", 32'(bus.irq), 32'd0);
    bus.irq_enable = 1'b1;
    #1;
    chk("unmask_irq", 32'(bus.irq), 32'd1);

    // Disarmed edge changes nothing.
    bus.ack = 1'b1;
    step("disarm_ack");
    bus.ack = 1'b0;
    repeat (6) step("disarm_drain");
    bus.counter_set = 1'b0;
    pulse_int("disarm_ev");
    chk("disarm_pending", 32'(bus.pending), 32'd0);
    chk("disarm_pulse", 32'(bus.irq_pulse), 32'd0);
    chk("disarm_events", 32'(bus.event_count), 32'd3);
    bus.counter_set = 1'b1;

    // Retrigger: events two cycles apart give one unbroken pulse of 6 cycles.
    hi_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      bus.interrupting = (i == 0 || i == 2);
      step("retrig");
      if (bus.irq_pulse) hi_cnt++;
      if (i >= 0 && i <= 5) chk("retrig_cont", 32'(bus.irq_pulse), 32'd1);
    end
    chk("retrig_len", 32'(hi_cnt), 32'd6);

    // Clear coinciding with an event.
    bus.clear_stats  = 1'b1;
    bus.interrupting = 1'b1;
    step("clr_ev");
    bus.clear_stats  = 1'b0;
    bus.interrupting = 1'b0;
    chk("clr_ev_events", 32'(bus.event_count), 32'd0);
    chk("clr_ev_missed", 32'(bus.missed_count), 32'd0);
    chk("clr_ev_pending", 32'(bus.pending), 32'd1);

    // Asynchronous reset between edges while pending and pulsing, level held through release.
    bus.interrupting = 1'b1;
    step("pre_rst");
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_pending", 32'(bus.pending), 32'd0);
    chk("arst_irq", 32'(bus.irq), 32'd0);
    chk("arst_pulse", 32'(bus.irq_pulse), 32'd0);
    chk("arst_missed", 32'(bus.missed_count), 32'd0);
    chk("arst_events", 32'(bus.event_count), 32'd0);
    step("in_rst");
    rst_n = 1'b1;
    step("rel_rst");
    repeat (3) step("rel_hold");
    chk("rel_events", 32'(bus.event_count), 32'd1);
    bus.interrupting = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.interrupting = ($urandom_range(0, 99) < 50);
      bus.counter_set  = ($urandom_range(0, 99) < 85);
      bus.irq_enable   = ($urandom_range(0, 99) < 70);
      bus.ack          = ($urandom_range(0, 99) < 15);
      bus.clear_stats  = ($urandom_range(0, 99) < 2);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
